// File: rtl/mouse_packet_tracker.sv
// Parametrised PS/2 mouse packet tracker.
// Parses the PS/2 controller byte stream into 3-byte packets, or 4-byte packets
// when WHEEL_EN=1. It keeps a clamped cursor position, the button state and a
// saturating scroll-wheel accumulator. A bad header byte or a stalled packet
// makes it resynchronise.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   enable_tracking   0 freezes x_pos/y_pos/wheel_pos
//   byte_valid/data   one-cycle strobe with the received byte
//   x_pos, y_pos      clamped cursor position (X rightward, Y downward)
//   wheel_pos         signed wheel accumulator, scroll-up positive
//   buttons           {middle, right, left}
//   packet_valid      one-cycle pulse per completed packet
//   sync_error        one-cycle pulse on dropped header byte or timeout
//   packet_count      completed packets, wrapping
module mouse_packet_tracker #(
   parameter int unsigned COORD_W     = 10,
   parameter int unsigned XMIN        = 0,
   parameter int unsigned YMIN        = 0,
   parameter int unsigned XMAX        = 639,
   parameter int unsigned YMAX        = 479,
   parameter int unsigned XSTART      = 319,
   parameter int unsigned YSTART      = 239,
   parameter int unsigned WHEEL_EN    = 0,
   parameter int unsigned SPEED_SHIFT = 0,
   parameter int unsigned INIT_BYTES  = 2,
   parameter int unsigned TIMEOUT     = 1000000
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable_tracking,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic [COORD_W-1:0] x_pos,
   output logic [COORD_W-1:0] y_pos,
   output logic signed [7:0]  wheel_pos,
   output logic [2:0]         buttons,
   output logic               packet_valid,
   output logic               sync_error,
   output logic [15:0]        packet_count
);

   localparam int unsigned ACC_W  = COORD_W + 6;
   localparam int unsigned INIT_W = (INIT_BYTES < 2) ? 1 : $clog2(INIT_BYTES + 1);
   localparam int unsigned TO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic signed [ACC_W-1:0] XMIN_S = ACC_W'(XMIN);
   localparam logic signed [ACC_W-1:0] XMAX_S = ACC_W'(XMAX);
   localparam logic signed [ACC_W-1:0] YMIN_S = ACC_W'(YMIN);
   localparam logic signed [ACC_W-1:0] YMAX_S = ACC_W'(YMAX);

   typedef enum logic [2:0] {S_INIT, S_B1, S_B2, S_B3, S_B4, S_UPDATE} state_t;

   localparam state_t RESET_STATE = (INIT_BYTES == 0) ? S_B1 : S_INIT;

   state_t              state, state_d;
   logic [1:0]          hdr_ovf, hdr_ovf_d;      // {y, x} overflow flags
   logic [1:0]          hdr_sign, hdr_sign_d;    // {y, x} delta sign bits
   logic [2:0]          hdr_btn, hdr_btn_d;
   logic [7:0]          dx_byte, dx_byte_d;
   logic [7:0]          dy_byte, dy_byte_d;
   logic [3:0]          z_nib, z_nib_d;
   logic [INIT_W-1:0]   init_cnt, init_cnt_d;
   logic [TO_W-1:0]     to_cnt, to_cnt_d;

   logic [COORD_W-1:0]  x_d, y_d;
   logic signed [7:0]   wheel_d;
   logic [2:0]          buttons_d;
   logic                packet_valid_d, sync_error_d;
   logic [15:0]         packet_count_d;

   logic signed [8:0]       dx9, dy9, wsum;
   logic signed [ACC_W-1:0] dx_s, dy_s, nx, ny;
   logic [COORD_W-1:0]      x_clamp, y_clamp;
   logic signed [7:0]       w_sat;

   // Packet arithmetic: scaled signed deltas, clamped position, saturating wheel.
   always_comb begin
      dx9  = hdr_ovf[0] ? 9'sd0 : $signed({hdr_sign[0], dx_byte});
      dy9  = hdr_ovf[1] ? 9'sd0 : $signed({hdr_sign[1], dy_byte});
      dx_s = ACC_W'(dx9) <<< SPEED_SHIFT;
      dy_s = ACC_W'(dy9) <<< SPEED_SHIFT;
      nx   = $signed({6'd0, x_pos}) + dx_s;
      // Y grows downward on screen, but mouse Y is positive upward.
      ny   = $signed({6'd0, y_pos}) - dy_s;

      if (nx < XMIN_S)      x_clamp = COORD_W'(XMIN);
      else if (nx > XMAX_S) x_clamp = COORD_W'(XMAX);
      else                  x_clamp = nx[COORD_W-1:0];

      if (ny < YMIN_S)      y_clamp = COORD_W'(YMIN);
      else if (ny > YMAX_S) y_clamp = COORD_W'(YMAX);
      else                  y_clamp = ny[COORD_W-1:0];

      // Z is positive for scroll-down, so subtract it to make scroll-up positive.
      wsum = $signed({wheel_pos[7], wheel_pos}) - $signed({{5{z_nib[3]}}, z_nib});
      if (wsum > 9'sd127)       w_sat = 8'sh7F;
      else if (wsum < -9'sd128) w_sat = -8'sd128;
      else                      w_sat = wsum[7:0];
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d        = state;
      hdr_ovf_d      = hdr_ovf;
      hdr_sign_d     = hdr_sign;
      hdr_btn_d      = hdr_btn;
      dx_byte_d      = dx_byte;
      dy_byte_d      = dy_byte;
      z_nib_d        = z_nib;
      init_cnt_d     = init_cnt;
      to_cnt_d       = '0;
      x_d            = x_pos;
      y_d            = y_pos;
      wheel_d        = wheel_pos;
      buttons_d      = buttons;
      packet_valid_d = 1'b0;
      sync_error_d   = 1'b0;
      packet_count_d = packet_count;

      case (state)
         S_INIT: begin
            if (byte_valid) begin
               if (init_cnt == INIT_W'(INIT_BYTES - 1)) begin
                  state_d    = S_B1;
                  init_cnt_d = '0;
               end else begin
                  init_cnt_d = init_cnt + INIT_W'(1);
               end
            end
         end

         // UPDATE applies the packet and also treats a same-cycle byte as a header.
         S_B1, S_UPDATE: begin
            if (state == S_UPDATE) begin
               packet_valid_d = 1'b1;
               packet_count_d = packet_count + 16'd1;
               buttons_d      = hdr_btn;
               if (enable_tracking) begin
                  x_d = x_clamp;
                  y_d = y_clamp;
                  if (WHEEL_EN != 0) wheel_d = w_sat;
               end
            end
            state_d = S_B1;
            if (byte_valid) begin
               // Bit 3 is always set in a valid header byte.
               if (byte_data[3]) begin
                  hdr_ovf_d  = byte_data[7:6];
                  hdr_sign_d = byte_data[5:4];
                  hdr_btn_d  = byte_data[2:0];
                  state_d    = S_B2;
               end else begin
                  sync_error_d = 1'b1;
               end
            end
         end

         S_B2, S_B3, S_B4: begin
            if (byte_valid) begin
               case (state)
                  S_B2: begin
                     dx_byte_d = byte_data;
                     state_d   = S_B3;
                  end
                  S_B3: begin
                     dy_byte_d = byte_data;
                     state_d   = (WHEEL_EN != 0) ? S_B4 : S_UPDATE;
                  end
                  default: begin
                     z_nib_d = byte_data[3:0];
                     state_d = S_UPDATE;
                  end
               endcase
            end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
               // Stalled packet: drop it and look for a new header.
               state_d      = S_B1;
               sync_error_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt + TO_W'(1);
            end
         end

         default: state_d = S_B1;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= RESET_STATE;
         hdr_ovf      <= '0;
         hdr_sign     <= '0;
         hdr_btn      <= '0;
         dx_byte      <= '0;
         dy_byte      <= '0;
         z_nib        <= '0;
         init_cnt     <= '0;
         to_cnt       <= '0;
         x_pos        <= COORD_W'(XSTART);
         y_pos        <= COORD_W'(YSTART);
         wheel_pos    <= '0;
         buttons      <= '0;
         packet_valid <= 1'b0;
         sync_error   <= 1'b0;
         packet_count <= '0;
      end else begin
         state        <= state_d;
         hdr_ovf      <= hdr_ovf_d;
         hdr_sign     <= hdr_sign_d;
         hdr_btn      <= hdr_btn_d;
         dx_byte      <= dx_byte_d;
         dy_byte      <= dy_byte_d;
         z_nib        <= z_nib_d;
         init_cnt     <= init_cnt_d;
         to_cnt       <= to_cnt_d;
         x_pos        <= x_d;
         y_pos        <= y_d;
         wheel_pos    <= wheel_d;
         buttons      <= buttons_d;
         packet_valid <= packet_valid_d;
         sync_error   <= sync_error_d;
         packet_count <= packet_count_d;
      end
   end

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Directed testbench for mouse_packet_tracker. Instance u0 uses the 3-byte
// format and a short timeout. Instance u1 uses wheel packets with a speed
// shift of 1. The sel signal steers byte_valid to one instance or the other.
module tb_mouse_packet_tracker;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable_tracking;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       sel;
   logic       bv0, bv1;

   logic [9:0]        x0, y0, x1, y1;
   logic signed [7:0] w0, w1;
   logic [2:0]        btn0, btn1;
   logic              pv0, pv1, se0, se1;
   logic [15:0]       cnt0, cnt1;

   int checks = 0;
   int errors = 0;

   logic [7:0] burst [6] = '{8'h08, 8'h01, 8'h00, 8'h08, 8'h01, 8'h00};

   always #5 clock = ~clock;

   assign bv0 = byte_valid & ~sel;
   assign bv1 = byte_valid & sel;

   mouse_packet_tracker #(.TIMEOUT(100)) u0 (
      .clock(clock), .reset(reset), .enable_tracking(enable_tracking),
      .byte_valid(bv0), .byte_data(byte_data),
      .x_pos(x0), .y_pos(y0), .wheel_pos(w0), .buttons(btn0),
      .packet_valid(pv0), .sync_error(se0), .packet_count(cnt0));

   mouse_packet_tracker #(.TIMEOUT(100), .WHEEL_EN(1), .SPEED_SHIFT(1)) u1 (
      .clock(clock), .reset(reset), .enable_tracking(enable_tracking),
      .byte_valid(bv1), .byte_data(byte_data),
      .x_pos(x1), .y_pos(y1), .wheel_pos(w1), .buttons(btn1),
      .packet_valid(pv1), .sync_error(se1), .packet_count(cnt1));

   task automatic check(input string tag, input logic signed [63:0] got,
                        input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One byte strobe, followed by one idle cycle.
   task automatic send_byte(input logic [7:0] d);
      @(negedge clock);
      byte_valid = 1'b1;
      byte_data  = d;
      @(negedge clock);
      byte_valid = 1'b0;
   endtask

   // Send a packet, then wait until the cycle in which packet_valid is high.
   task automatic send_pkt(input int n, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] c, input logic [7:0] d);
      send_byte(a);
      send_byte(b);
      send_byte(c);
      if (n == 4) send_byte(d);
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      reset           = 1'b1;
      enable_tracking = 1'b1;
      byte_valid      = 1'b0;
      byte_data       = 8'h00;
      sel             = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Reset values
      check("rst_x", x0, 319);
      check("rst_y", y0, 239);
      check("rst_wheel", w0, 0);
      check("rst_btn", btn0, 0);
      check("rst_pv", pv0, 0);
      check("rst_se", se0, 0);
      check("rst_cnt", cnt0, 0);

      // Two init bytes, then the basic packet
      send_byte(8'hFA);
      send_byte(8'hAA);
      send_byte(8'h09);
      send_byte(8'h05);
      send_byte(8'h03);
      check("pv_before_update", pv0, 0);
      @(negedge clock);
      check("pkt1_pv", pv0, 1);
      check("pkt1_x", x0, 324);
      check("pkt1_y", y0, 236);
      check("pkt1_btn", btn0, 1);
      check("pkt1_cnt", cnt0, 1);
      @(negedge clock);
      check("pkt1_pv_drop", pv0, 0);

      // Negative X deltas down to the left clamp
      do_reset();
      send_byte(8'hFA);
      send_byte(8'hAA);
      send_pkt(3, 8'h18, 8'h80, 8'h00, 8'h00);
      check("neg1_x", x0, 191);
      send_pkt(3, 8'h18, 8'h80, 8'h00, 8'h00);
      check("neg2_x", x0, 63);
      send_pkt(3, 8'h18, 8'h80, 8'h00, 8'h00);
      check("neg3_x_clamp", x0, 0);
      check("neg3_y", y0, 239);

      // Positive X deltas up to the right clamp
      for (int i = 0; i < 4; i++) send_pkt(3, 8'h08, 8'h7F, 8'h00, 8'h00);
      check("pos4_x", x0, 508);
      send_pkt(3, 8'h08, 8'h5C, 8'h00, 8'h00);
      check("pos_x600", x0, 600);
      send_pkt(3, 8'h08, 8'h7F, 8'h00, 8'h00);
      check("pos_x_clamp", x0, 639);
      check("pos_cnt", cnt0, 9);

      // An X overflow flag zeroes the delta; buttons still update
      send_pkt(3, 8'h4A, 8'h10, 8'h00, 8'h00);
      check("ovf_pv", pv0, 1);
      check("ovf_x", x0, 639);
      check("ovf_btn", btn0, 2);

      // Tracking disabled: position holds, count and buttons still update
      enable_tracking = 1'b0;
      send_pkt(3, 8'h18, 8'hF0, 8'h00, 8'h00);
      check("dis_x", x0, 639);
      check("dis_y", y0, 239);
      check("dis_cnt", cnt0, 11);
      check("dis_btn", btn0, 0);
      enable_tracking = 1'b1;

      // A header byte without bit 3 is dropped
      do_reset();
      send_byte(8'hFA);
      send_byte(8'hAA);
      send_byte(8'h01);
      check("sync_se", se0, 1);
      @(negedge clock);
      check("sync_se_drop", se0, 0);
      send_pkt(3, 8'h08, 8'h01, 8'h00, 8'h00);
      check("sync_x", x0, 320);
      check("sync_cnt", cnt0, 1);

      // Back-to-back packets: the next header arrives during UPDATE
      foreach (burst[i]) begin
         @(negedge clock);
         byte_valid = 1'b1;
         byte_data  = burst[i];
      end
      @(negedge clock);
      byte_valid = 1'b0;
      repeat (2) @(negedge clock);
      check("burst_x", x0, 322);
      check("burst_cnt", cnt0, 3);
      check("burst_se", se0, 0);

      // A stalled partial packet times out after 100 idle cycles
      send_byte(8'h08);
      send_byte(8'h01);
      n = 0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clock);
         if (se0) begin
            n = i;
            break;
         end
      end
      check("timeout_cycles", n, 100);
      @(negedge clock);
      check("timeout_se_drop", se0, 0);
      send_pkt(3, 8'h0F, 8'h02, 8'h00, 8'h00);
      check("timeout_x", x0, 324);
      check("timeout_btn", btn0, 7);
      check("timeout_cnt", cnt0, 4);

      // Reset mid-packet; the next two bytes are consumed as init bytes
      send_byte(8'h08);
      send_byte(8'h05);
      do_reset();
      check("midrst_x", x0, 319);
      check("midrst_btn", btn0, 0);
      check("midrst_cnt", cnt0, 0);
      check("midrst_pv", pv0, 0);
      send_byte(8'h08);
      send_byte(8'h05);
      check("midrst_init_x", x0, 319);
      send_pkt(3, 8'h08, 8'h01, 8'h00, 8'h00);
      check("midrst_pkt_x", x0, 320);
      check("midrst_pkt_cnt", cnt0, 1);

      // Wheel packets with a speed shift of 1
      sel = 1'b1;
      check("u1_rst_wheel", w1, 0);
      send_byte(8'hFA);
      send_byte(8'hAA);
      send_pkt(4, 8'h08, 8'h02, 8'h00, 8'h0F);
      check("wheel1_pv", pv1, 1);
      check("wheel1_x", x1, 323);
      check("wheel1_w", w1, 1);
      for (int i = 0; i < 125; i++) send_pkt(4, 8'h08, 8'h02, 8'h00, 8'h0F);
      check("wheel126_w", w1, 126);
      for (int i = 0; i < 4; i++) send_pkt(4, 8'h08, 8'h02, 8'h00, 8'h0F);
      check("wheel_sat_w", w1, 127);
      check("wheel_cnt", cnt1, 130);
      check("wheel_x_clamp", x1, 639);
      check("u0_isolated_cnt", cnt0, 1);
      sel = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
